ahb_slave_mem: RTL and testbench



---
 rtl/ahb_slave_mem.sv | 174 +++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave backed by a word-addressed register memory.
// Supports byte/halfword/word writes with little-endian lanes, a fixed number
// of wait states per data phase and a registered read path with
// read-after-write bypass.
// Optional feature macro: AHB_SLAVE_ERR_EN (out-of-range addresses answer with
// a two-cycle ERROR response instead of aliasing into the memory).
//
// state | meaning
// IDLE  | no transfer in progress, ready and OKAY
// DATA  | data phase of a captured transfer, counting down wait states
// ERR1  | first ERROR cycle (not ready)
// ERR2  | second ERROR cycle (ready), may capture a new transfer
module ahb_slave_mem #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_DATA  = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;
  logic              out_of_range;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [31:0]       hrdata_q;
  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  widx_q;
  logic [IDX_W-1:0]  ridx;
  logic [3:0]        strb;
  logic [31:0]       wr_merged;
  logic              wr_done;
  logic [31:0]       rd_value;

`ifdef AHB_SLAVE_ERR_EN
  logic unused_bits;
  assign unused_bits  = htrans[0];
  assign out_of_range = |haddr[31:ADDR_W];
`else
  logic unused_bits;
  assign unused_bits  = ^{htrans[0], haddr[31:ADDR_W]};
  assign out_of_range = 1'b0;
`endif

  assign widx_q = addr_q[ADDR_W-1:2];
  assign ridx   = haddr[ADDR_W-1:2];

  // Byte-lane strobes for the captured transfer; sizes above word act as word.
  always_comb begin
    strb = 4'b1111;
    case (size_q)
      3'b000:  strb = 4'b0001 << addr_q[1:0];
      3'b001:  strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Merge the write data into the currently stored word lane by lane.
  always_comb begin
    wr_merged = mem[widx_q];
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) wr_merged[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  assign wr_done = (state_q == DATA) && (cnt_q == 4'd0) && write_q;

  // Read value at capture, forwarding a write that completes at the same edge.
  always_comb begin
    rd_value = mem[ridx];
    if (wr_done && (ridx == widx_q)) rd_value = wr_merged;
  end

  // State and wait counter register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait countdown, handshake outputs and capture qualification.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    capture   = 1'b0;
    case (state_q)
      IDLE: ;
      DATA: begin
        hreadyout = (cnt_q == 4'd0);
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = IDLE;
      end
`ifdef AHB_SLAVE_ERR_EN
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
        state_d   = ERR2;
      end
      ERR2: begin
        hresp   = RESP_ERROR;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Only accept a new address phase while this slave is itself ready, so
    // hready_in has no effect during our own wait states.
    capture = hsel && hready_in && htrans[1] && hreadyout;
    if (capture) begin
      if (out_of_range) begin
        state_d = ERR1;
        cnt_d   = 4'd0;
      end else begin
        state_d = DATA;
        cnt_d   = WAIT_LD;
      end
    end
  end

  // Address-phase registers, memory array and registered read data.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'b000;
      hrdata_q <= 32'h0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_DATA;
    end else begin
      if (wr_done) mem[widx_q] <= wr_merged;
      if (capture) begin
        addr_q  <= haddr[ADDR_W-1:0];
        write_q <= hwrite && !out_of_range;
        size_q  <= hsize;
      end
      if (capture && !hwrite && !out_of_range && (WAIT_CYCLES == 0))
        hrdata_q <= rd_value;
      else if ((state_q == DATA) && (cnt_q == 4'd1) && !write_q)
        hrdata_q <= mem[widx_q];
      else if (hreadyout)
        hrdata_q <= 32'h0;
    end
  end

  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 0, 3 and 5 wait
// states share the address/data bus and have individual select lines.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic [1:0]  resp  [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(0), .RESET_DATA(32'h0000_0000)) u0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata[0]), .hreadyout(rdy[0]), .hresp(resp[0]));

  ahb_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(3), .RESET_DATA(32'h0000_0000)) u3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata[1]), .hreadyout(rdy[1]), .hresp(resp[1]));

  ahb_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(5), .RESET_DATA(32'h5A5A_0000)) u5 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[2]), .haddr(haddr), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata[2]), .hreadyout(rdy[2]), .hresp(resp[2]));

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic ap(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel    = 3'b000;
    hsel[d] = 1'b1;
    haddr   = a;
    hwrite  = w;
    hsize   = sz;
    htrans  = 2'b10;
  endtask

  task automatic idle();
    hsel   = 3'b000;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    hreset = 1'b1; idle(); haddr = 32'h0; hsize = 3'b010; hwdata = 32'h0; hready_in = 1'b1;
    tick(); tick();
    chk("rst_rdy", 32'(rdy[0]), 32'h1);
    chk("rst_resp", 32'(resp[0]), 32'h0);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_rdy_w5", 32'(rdy[2]), 32'h1);
    hreset = 1'b0;

    // read after reset
    ap(0, 32'h10, 1'b0, 3'b010); tick(); idle();
    chk("rd0_rdy", 32'(rdy[0]), 32'h1);
    chk("rd0_resp", 32'(resp[0]), 32'h0);
    chk("rd0_data", rdata[0], 32'h0);
    tick();

    // back-to-back word write then read with bypass
    ap(0, 32'h04, 1'b1, 3'b010); tick();
    hwdata = 32'hDEAD_BEEF; ap(0, 32'h04, 1'b0, 3'b010); tick(); idle();
    chk("b2b_rdy", 32'(rdy[0]), 32'h1);
    chk("b2b_bypass", rdata[0], 32'hDEAD_BEEF);
    tick();
    chk("idle_rdata", rdata[0], 32'h0);

    // byte and halfword lanes
    ap(0, 32'h08, 1'b1, 3'b010); tick();
    hwdata = 32'h1122_3344; ap(0, 32'h09, 1'b1, 3'b000); tick();
    hwdata = 32'h0000_AA00; ap(0, 32'h0A, 1'b1, 3'b001); tick();
    hwdata = 32'hBBBB_0000; ap(0, 32'h08, 1'b0, 3'b010); tick(); idle();
    chk("lanes_bh", rdata[0], 32'hBBBB_AA44);
    tick();
    ap(0, 32'h0B, 1'b1, 3'b000); tick(); hwdata = 32'h5566_7788; idle(); tick();
    ap(0, 32'h08, 1'b0, 3'b010); tick(); idle();
    chk("lane3_byte", rdata[0], 32'h55BB_AA44);
    tick();
    ap(0, 32'h01, 1'b1, 3'b001); tick(); hwdata = 32'h1234_CAFE; idle(); tick();
    ap(0, 32'h00, 1'b0, 3'b010); tick(); idle();
    chk("half_odd_addr", rdata[0], 32'h0000_CAFE);
    tick();
    ap(0, 32'h0C, 1'b1, 3'b011); tick(); hwdata = 32'hCAFE_F00D; idle(); tick();
    ap(0, 32'h0C, 1'b0, 3'b010); tick(); idle();
    chk("size3_as_word", rdata[0], 32'hCAFE_F00D);
    tick();

    // transfers that must not be captured
    hwdata = 32'hFFFF_FFFF;
    hsel = 3'b000; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h08; hsize = 3'b010; tick();
    chk("unsel_rdy", 32'(rdy[0]), 32'h1);
    hsel[0] = 1'b1; htrans = 2'b01; tick();
    chk("busy_rdy", 32'(rdy[0]), 32'h1);
    chk("busy_resp", 32'(resp[0]), 32'h0);
    hready_in = 1'b0; ap(0, 32'h08, 1'b1, 3'b010); tick();
    hready_in = 1'b1; idle(); tick();
    ap(0, 32'h08, 1'b0, 3'b010); tick(); idle();
    chk("no_capture_mem", rdata[0], 32'h55BB_AA44);
    tick();

    // out-of-range write
    ap(0, 32'h0000_0400, 1'b1, 3'b010); tick(); hwdata = 32'h1234_5678; idle();
`ifdef AHB_SLAVE_ERR_EN
    chk("err1_rdy", 32'(rdy[0]), 32'h0);
    chk("err1_resp", 32'(resp[0]), 32'h1);
    tick();
    chk("err2_rdy", 32'(rdy[0]), 32'h1);
    chk("err2_resp", 32'(resp[0]), 32'h1);
    tick();
    chk("err_done_resp", 32'(resp[0]), 32'h0);
`else
    chk("alias_rdy", 32'(rdy[0]), 32'h1);
    chk("alias_resp", 32'(resp[0]), 32'h0);
    tick();
`endif
    ap(0, 32'h00, 1'b0, 3'b010); tick(); idle();
`ifdef AHB_SLAVE_ERR_EN
    chk("err_mem_kept", rdata[0], 32'h0000_CAFE);
`else
    chk("alias_mem", rdata[0], 32'h1234_5678);
`endif
    chk("word0_resp", 32'(resp[0]), 32'h0);
    tick();

    // three wait states: write then read
    ap(1, 32'h04, 1'b1, 3'b010); tick(); idle(); hwdata = 32'hA5A5_0F0F;
    for (int i = 0; i < 3; i++) begin
      chk("ws_wr_wait", 32'(rdy[1]), 32'h0);
      tick();
    end
    chk("ws_wr_final", 32'(rdy[1]), 32'h1);
    tick();
    ap(1, 32'h04, 1'b0, 3'b010); tick(); idle(); hwdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_rd_wait", 32'(rdy[1]), 32'h0);
      tick();
    end
    chk("ws_rd_rdy", 32'(rdy[1]), 32'h1);
    chk("ws_rd_data", rdata[1], 32'hA5A5_0F0F);
    tick();
    chk("ws_rd_after", rdata[1], 32'h0);

    // reset during the second wait cycle of a five-wait write
    ap(2, 32'h0C, 1'b1, 3'b010); tick(); idle(); hwdata = 32'hFFFF_FFFF;
    chk("w5_wait1", 32'(rdy[2]), 32'h0);
    tick();
    chk("w5_wait2", 32'(rdy[2]), 32'h0);
    hreset = 1'b1; tick(); hreset = 1'b0;
    chk("rst_mid_rdy", 32'(rdy[2]), 32'h1);
    chk("rst_mid_resp", 32'(resp[2]), 32'h0);
    ap(2, 32'h0C, 1'b0, 3'b010); tick(); idle();
    for (int i = 0; i < 5; i++) begin
      chk("w5_rd_wait", 32'(rdy[2]), 32'h0);
      tick();
    end
    chk("w5_rd_rdy", 32'(rdy[2]), 32'h1);
    chk("rst_mid_mem", rdata[2], 32'h5A5A_0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
